// File: rtl/img_restorer.sv
// img_restorer: pipelined inverse RGB colour map with VGA timing delay and per-frame pixel counting.
// Define IMG_RESTORER_CHECK_EN to add the reference-pixel error checker.
module img_restorer #(
  parameter int   PIPE_DEPTH = 2,
  parameter int   CNT_W      = 20,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bypass_i,
  input  logic [2:0]       rgb_i,
  input  logic             de_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
`ifdef IMG_RESTORER_CHECK_EN
  input  logic [2:0]       ref_rgb_i,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] frame_err_o,
`endif
  output logic [2:0]       rgb_o,
  output logic             de_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [CNT_W-1:0] px_cnt_o,
  output logic [CNT_W-1:0] frame_px_o,
  output logic             frame_done_o
);

  typedef enum logic {
    WAIT_FRAME,
    COUNT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [2:0] inv_map(input logic [2:0] c);
    logic [2:0] r;
    unique case (c)
      3'd0: r = 3'd4;
      3'd1: r = 3'd0;
      3'd2: r = 3'd1;
      3'd3: r = 3'd3;
      3'd4: r = 3'd2;
      3'd5: r = 3'd7;
      3'd6: r = 3'd5;
      3'd7: r = 3'd6;
    endcase
    return r;
  endfunction

  logic [2:0] rgb_q [PIPE_DEPTH];
  logic       de_q  [PIPE_DEPTH];
  logic       hs_q  [PIPE_DEPTH];
  logic       vs_q  [PIPE_DEPTH];
  logic [2:0] s1_rgb;

  // Stage-1 pixel: blanking forces black, otherwise mapped or bypassed
  always_comb begin
    s1_rgb = 3'b000;
    if (de_i) begin
      s1_rgb = bypass_i ? rgb_i : inv_map(rgb_i);
    end
  end

  // Pixel/timing delay line; stage 1 takes the new pixel, the rest shift
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        rgb_q[i] <= 3'b000;
        de_q[i]  <= 1'b0;
        hs_q[i]  <= SYNC_IDLE;
        vs_q[i]  <= SYNC_IDLE;
      end
    end else begin
      rgb_q[0] <= s1_rgb;
      de_q[0]  <= de_i;
      hs_q[0]  <= hsync_i;
      vs_q[0]  <= vsync_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        rgb_q[i] <= rgb_q[i-1];
        de_q[i]  <= de_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  assign rgb_o   = rgb_q[PIPE_DEPTH-1];
  assign de_o    = de_q[PIPE_DEPTH-1];
  assign hsync_o = hs_q[PIPE_DEPTH-1];
  assign vsync_o = vs_q[PIPE_DEPTH-1];

  state_t state;
  logic   vs_prev;
  logic   frame_edge;

  // Frame boundary is the falling edge of the delayed vsync
  assign frame_edge = vs_prev & ~vsync_o;

  // Frame FSM: skip the partial first frame, then count active pixels
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= WAIT_FRAME;
      vs_prev      <= SYNC_IDLE;
      px_cnt_o     <= '0;
      frame_px_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      vs_prev      <= vsync_o;
      frame_done_o <= 1'b0;
      unique case (state)
        WAIT_FRAME: begin
          if (frame_edge) begin
            state    <= COUNT;
            px_cnt_o <= de_o ? CNT_ONE : '0;
          end
        end
        COUNT: begin
          if (frame_edge) begin
            frame_px_o   <= px_cnt_o;
            frame_done_o <= 1'b1;
            px_cnt_o     <= de_o ? CNT_ONE : '0;
          end else if (de_o && px_cnt_o != CNT_MAX) begin
            px_cnt_o <= px_cnt_o + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef IMG_RESTORER_CHECK_EN
  logic [2:0] ref_q [PIPE_DEPTH];
  logic       byp_q [PIPE_DEPTH];
  logic       mism;

  // Reference pixel and bypass flag travel alongside the pixel
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        ref_q[i] <= 3'b000;
        byp_q[i] <= 1'b0;
      end
    end else begin
      ref_q[0] <= ref_rgb_i;
      byp_q[0] <= bypass_i;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        ref_q[i] <= ref_q[i-1];
        byp_q[i] <= byp_q[i-1];
      end
    end
  end

  assign mism = de_o & ~byp_q[PIPE_DEPTH-1]
              & (rgb_o != ref_q[PIPE_DEPTH-1]);

  // Per-frame mismatch counter, same framing as the pixel counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o   <= '0;
      frame_err_o <= '0;
    end else begin
      unique case (state)
        WAIT_FRAME: begin
          if (frame_edge) begin
            err_cnt_o <= mism ? CNT_ONE : '0;
          end
        end
        COUNT: begin
          if (frame_edge) begin
            frame_err_o <= err_cnt_o;
            err_cnt_o   <= mism ? CNT_ONE : '0;
          end else if (mism && err_cnt_o != CNT_MAX) begin
            err_cnt_o <= err_cnt_o + CNT_ONE;
          end
        end
      endcase
    end
  end
`endif

endmodule
